// File: rtl/hs_pkg.sv
// Shared constants and helpers for the valid/ready transmit queue family.
package hs_pkg;

   localparam int   HS_DATA_W   = 32;
   localparam int   HS_DEPTH    = 4;
   localparam logic HS_DATA_RST = 1'b0;

   // One extra wrap bit beyond the index lets full and empty be told apart.
   function automatic int hs_ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/hs_tx_queue_if.sv
// Valid/ready channel: master drives data/valid, slave drives ready.
interface hs_tx_queue_if #(
   parameter int DATA_W = hs_pkg::HS_DATA_W
);

   logic [DATA_W-1:0] data;
   logic              valid;
   logic              ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/hs_fifo_mem.sv
// Plain register array: synchronous write, asynchronous read by index.
module hs_fifo_mem #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_W-1:0]        rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // NOTE: storage has no reset; the queue pointers alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/hs_tx_queue.sv
// Circular FIFO between a producer and a valid/ready slave.
// Optional counters enabled by defining HS_TX_QUEUE_STATS_EN.
module hs_tx_queue
   import hs_pkg::*;
#(
   parameter int DATA_W    = HS_DATA_W,
   parameter int DEPTH     = HS_DEPTH,   // power of 2, at least 2
   parameter int AFULL_LVL = DEPTH - 1
) (
   input  logic                         clk,
   input  logic                         reset,
   hs_tx_queue_if.slave                 prod,
   hs_tx_queue_if.master                tx,
   output logic [hs_ptr_w(DEPTH)-1:0]   count,
   output logic                         almost_full,
   output logic                         overflow
`ifdef HS_TX_QUEUE_STATS_EN
   ,
   output logic [31:0]                  xfer_cnt,
   output logic [31:0]                  stall_cnt
`endif
);

   localparam int PW = hs_ptr_w(DEPTH);
   localparam int AW = PW - 1;

   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [DATA_W-1:0] rdata;
   logic              empty;
   logic              full;
   logic              valid;
   logic              wr_en;
   logic              rd_en;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign valid = !empty;

   // Producer acceptance depends only on occupancy, never on the slave's ready.
   assign prod.ready = !full && !reset;
   assign wr_en      = prod.valid && prod.ready;
   assign rd_en      = valid && tx.ready;

   assign tx.valid    = valid;
   assign tx.data     = valid ? rdata : {DATA_W{HS_DATA_RST}};
   assign count       = wr_ptr - rd_ptr;
   assign almost_full = (count >= PW'(AFULL_LVL));

   hs_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (prod.data),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (rdata)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PW'(1);
         if (rd_en) rd_ptr <= rd_ptr + PW'(1);
         if (prod.valid && full) overflow <= 1'b1;
      end
   end

`ifdef HS_TX_QUEUE_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         xfer_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         if (rd_en)               xfer_cnt  <= xfer_cnt + 32'd1;
         if (valid && !tx.ready)  stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hs_tx_queue.sv
// Directed self-checking bench for hs_tx_queue (DEPTH=4, DATA_W=32).
module tb_hs_tx_queue;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] count;
   logic       almost_full;
   logic       overflow;
`ifdef HS_TX_QUEUE_STATS_EN
   logic [31:0] xfer_cnt;
   logic [31:0] stall_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   hs_tx_queue_if #(.DATA_W(32)) prod_if ();
   hs_tx_queue_if #(.DATA_W(32)) tx_if ();

   hs_tx_queue #(
      .DATA_W    (32),
      .DEPTH     (4),
      .AFULL_LVL (3)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .prod        (prod_if),
      .tx          (tx_if),
      .count       (count),
      .almost_full (almost_full),
      .overflow    (overflow)
`ifdef HS_TX_QUEUE_STATS_EN
      ,
      .xfer_cnt    (xfer_cnt),
      .stall_cnt   (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      prod_if.valid = 1'b1;
      prod_if.data  = 32'hAAAA_5555;
      tx_if.ready   = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      checks++; if (tx_if.valid !== 1'b0)   begin failures++; $display("FAIL rst_valid got=%b exp=0", tx_if.valid); end
      checks++; if (tx_if.data !== 32'h0)   begin failures++; $display("FAIL rst_data got=%h exp=0", tx_if.data); end
      checks++; if (count !== 3'd0)         begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
      checks++; if (prod_if.ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", prod_if.ready); end
      checks++; if (overflow !== 1'b0)      begin failures++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
      checks++; if (almost_full !== 1'b0)   begin failures++; $display("FAIL rst_afull got=%b exp=0", almost_full); end
      reset = 1'b0;
      prod_if.valid = 1'b0;
      #1;
      checks++; if (prod_if.ready !== 1'b1) begin failures++; $display("FAIL rel_in_ready got=%b exp=1", prod_if.ready); end
      tick();
      checks++; if (count !== 3'd0)         begin failures++; $display("FAIL rel_count got=%0d exp=0", count); end
      checks++; if (tx_if.valid !== 1'b0)   begin failures++; $display("FAIL rel_valid got=%b exp=0", tx_if.valid); end
   endtask

   task automatic test_single();
      tx_if.ready   = 1'b1;
      prod_if.valid = 1'b1;
      prod_if.data  = 32'h2022_0503;
      tick();
      prod_if.valid = 1'b0;
      checks++; if (tx_if.valid !== 1'b1)         begin failures++; $display("FAIL single_valid got=%b exp=1", tx_if.valid); end
      checks++; if (tx_if.data !== 32'h2022_0503) begin failures++; $display("FAIL single_data got=%h exp=20220503", tx_if.data); end
      checks++; if (count !== 3'd1)               begin failures++; $display("FAIL single_count got=%0d exp=1", count); end
      tick();
      checks++; if (tx_if.valid !== 1'b0)         begin failures++; $display("FAIL single_drain_valid got=%b exp=0", tx_if.valid); end
      checks++; if (count !== 3'd0)               begin failures++; $display("FAIL single_drain_count got=%0d exp=0", count); end
      checks++; if (tx_if.data !== 32'h0)         begin failures++; $display("FAIL single_idle_data got=%h exp=0", tx_if.data); end
   endtask

   task automatic test_backpressure();
      tx_if.ready   = 1'b0;
      prod_if.valid = 1'b1;
      prod_if.data  = 32'h1000_0006;
      tick();
      prod_if.data  = 32'h0000_0001;
      tick();
      prod_if.valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++; if (tx_if.data !== 32'h1000_0006) begin failures++; $display("FAIL bp_hold_data[%0d] got=%h exp=10000006", i, tx_if.data); end
         checks++; if (tx_if.valid !== 1'b1 || count !== 3'd2) begin failures++; $display("FAIL bp_hold_state[%0d] got=%b/%0d exp=1/2", i, tx_if.valid, count); end
         tick();
      end
      tx_if.ready = 1'b1;
      checks++; if (tx_if.data !== 32'h1000_0006) begin failures++; $display("FAIL bp_first got=%h exp=10000006", tx_if.data); end
      tick();
      checks++; if (tx_if.data !== 32'h0000_0001 || count !== 3'd1) begin failures++; $display("FAIL bp_second got=%h/%0d exp=00000001/1", tx_if.data, count); end
      tick();
      checks++; if (tx_if.valid !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL bp_empty got=%b/%0d exp=0/0", tx_if.valid, count); end
   endtask

   task automatic test_full_overflow();
      logic [3:0] exp_afull;
      exp_afull = 4'b1100;  // almost_full after writes 1..4 (count>=3)
      tx_if.ready   = 1'b0;
      prod_if.valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         prod_if.data = 32'(i);
         tick();
         checks++; if (count !== 3'(i)) begin failures++; $display("FAIL full_count[%0d] got=%0d exp=%0d", i, count, i); end
         checks++; if (almost_full !== exp_afull[i-1]) begin failures++; $display("FAIL full_afull[%0d] got=%b exp=%b", i, almost_full, exp_afull[i-1]); end
      end
      checks++; if (prod_if.ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", prod_if.ready); end
      checks++; if (overflow !== 1'b0)      begin failures++; $display("FAIL full_pre_ovf got=%b exp=0", overflow); end
      prod_if.data = 32'd5;
      tick();
      prod_if.valid = 1'b0;
      checks++; if (overflow !== 1'b1 || count !== 3'd4) begin failures++; $display("FAIL full_ovf got=%b/%0d exp=1/4", overflow, count); end
      tx_if.ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         checks++; if (tx_if.valid !== 1'b1 || tx_if.data !== 32'(i)) begin failures++; $display("FAIL drain[%0d] got=%b/%h exp=1/%h", i, tx_if.valid, tx_if.data, 32'(i)); end
         tick();
      end
      checks++; if (tx_if.valid !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL drain_end got=%b/%0d exp=0/0", tx_if.valid, count); end
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
   endtask

   task automatic test_stream();
      tx_if.ready   = 1'b1;
      prod_if.valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         prod_if.data = 32'h0000_0100 + 32'(i);
         tick();
         checks++; if (tx_if.valid !== 1'b1 || tx_if.data !== 32'h0000_0100 + 32'(i) || count !== 3'd1) begin
            failures++; $display("FAIL stream[%0d] got=%b/%h/%0d exp=1/%h/1", i, tx_if.valid, tx_if.data, count, 32'h100 + 32'(i));
         end
      end
      prod_if.valid = 1'b0;
      tick();
      checks++; if (tx_if.valid !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL stream_end got=%b/%0d exp=0/0", tx_if.valid, count); end
   endtask

   task automatic test_mid_reset();
      tx_if.ready   = 1'b0;
      prod_if.valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         prod_if.data = 32'hA000_0001 + 32'(i);
         tick();
      end
      prod_if.valid = 1'b0;
      checks++; if (count !== 3'd3 || almost_full !== 1'b1) begin failures++; $display("FAIL mr_pre got=%0d/%b exp=3/1", count, almost_full); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (tx_if.valid !== 1'b0 || count !== 3'd0 || tx_if.data !== 32'h0) begin failures++; $display("FAIL mr_post got=%b/%0d/%h exp=0/0/0", tx_if.valid, count, tx_if.data); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL mr_ovf_clear got=%b exp=0", overflow); end
`ifdef HS_TX_QUEUE_STATS_EN
      checks++; if (xfer_cnt !== 32'd0 || stall_cnt !== 32'd0) begin failures++; $display("FAIL mr_stats got=%0d/%0d exp=0/0", xfer_cnt, stall_cnt); end
`endif
      tx_if.ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (tx_if.valid !== 1'b0) begin failures++; $display("FAIL mr_stale[%0d] got=%b exp=0", i, tx_if.valid); end
      end
      tx_if.ready   = 1'b0;
      prod_if.valid = 1'b1;
      prod_if.data  = 32'hB000_000B;
      tick();
      prod_if.valid = 1'b0;
      tick();
      checks++; if (tx_if.data !== 32'hB000_000B || count !== 3'd1) begin failures++; $display("FAIL mr_fresh got=%h/%0d exp=b000000b/1", tx_if.data, count); end
`ifdef HS_TX_QUEUE_STATS_EN
      checks++; if (xfer_cnt !== 32'd0 || stall_cnt !== 32'd1) begin failures++; $display("FAIL mr_stall got=%0d/%0d exp=0/1", xfer_cnt, stall_cnt); end
`endif
      tx_if.ready = 1'b1;
      tick();
      checks++; if (tx_if.valid !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL mr_drain got=%b/%0d exp=0/0", tx_if.valid, count); end
`ifdef HS_TX_QUEUE_STATS_EN
      checks++; if (xfer_cnt !== 32'd1 || stall_cnt !== 32'd1) begin failures++; $display("FAIL mr_xfer got=%0d/%0d exp=1/1", xfer_cnt, stall_cnt); end
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_full_overflow();
      test_stream();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hs_tx_queue.md
Name: hs_tx_queue

Overview:
Parametrised successor to the single-word valid/ready master. Accepts words from a producer interface, buffers up to DEPTH words in a circular FIFO and drives them onto a valid/ready channel toward a slave, so back-to-back producer words are no longer lost while the slave holds ready low. Sits between the transmit-data source and any slave using the team's valid/ready handshake.

Parameters:
DATA_W, 32, width of in_data and data.
DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
AFULL_LVL, DEPTH-1, almost_full asserts when count is at least this value.

Ports:
clk  input  1  single clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
in_data  input  DATA_W  producer word.
in_valid  input  1  producer word present.
in_ready  output  1  queue can accept a word.
data  output  DATA_W  word presented to the slave.
valid  output  1  data is valid.
ready  input  1  slave accepts data.
count  output  $clog2(DEPTH)+1  words currently held, 0..DEPTH.
almost_full  output  1  count >= AFULL_LVL.
overflow  output  1  sticky; producer offered a word while in_ready was 0.

Behaviour:
- Reset (sampled at the clk edge while reset=1): rd_ptr=0, wr_ptr=0, count=0, valid=0, data=0, in_ready=0 while reset is high, in_ready=1 in the first cycle after release, almost_full=0, overflow=0. Memory contents are not reset.
- Reset mid-operation discards all queued words. Any handshake in the reset cycle is ignored.
- Write: when in_valid && in_ready at the edge, mem[wr_ptr]=in_data and wr_ptr increments.
- Read: when valid && ready at the edge, rd_ptr increments.
- Pointers are $clog2(DEPTH)+1 bits with an extra wrap bit and wrap naturally.
  - empty = pointers equal.
  - full = index bits equal and wrap bits differ.
- valid = !empty. data = mem[rd_ptr] when valid, otherwise 0. Both come from registered state only; there is no combinational path from in_* to outputs.
- in_ready = !full && !reset. There is no write-through when full, even if ready=1 in the same cycle.
- Latency: a word written at edge N makes valid=1 from cycle N+1. Minimum in-to-out latency is 1 cycle.
- Throughput: one write and one read per cycle are allowed simultaneously when 0 < count < DEPTH. In that case count is unchanged.
- Hold rule: while valid && !ready, data and valid must stay stable. valid never drops without a completed read.
- count: +1 on write only, -1 on read only, unchanged on both or neither.
- Empty and in_valid: the word is written and valid rises the next cycle. No read can occur in the same cycle.
- Full: in_ready=0. If in_valid=1 in that cycle, overflow sets at the edge and the word is dropped. overflow clears only by reset.
- Order is strictly FIFO. No word is duplicated or reordered across pointer wrap.

Optional Feature:
HS_TX_QUEUE_STATS_EN. When defined, the block adds two outputs:
- xfer_cnt [31:0]: counts completed valid&&ready transfers.
- stall_cnt [31:0]: counts cycles with valid && !ready.
Both reset to 0 and wrap modulo 2^32. When the macro is undefined, neither port exists and there is no counter logic; all other behaviour is identical.

Decomposition:
- Shared package hs_pkg holds:
  - the default constants HS_DATA_W=32 and HS_DEPTH=4;
  - a function giving pointer width ($clog2(DEPTH)+1);
  - reset constant HS_DATA_RST=0.
- One natural sub-module, hs_fifo_mem: a plain register array with synchronous write and asynchronous read by index. Pointers, flags and handshake logic stay in hs_tx_queue.

Test Plan:
- Reset: hold reset for 10 cycles with in_valid=1 -> valid=0, data=0, count=0, in_ready=0, overflow=0. In the first cycle after release, in_ready=1.
- Single word: write 32'h20220503 with ready=1 -> valid=1, data=32'h20220503 one cycle later; read completes on that cycle; count returns to 0.
- Backpressure: ready=0, write 32'h10000006 then 32'h00000001 -> data holds 32'h10000006 and count=2 until ready=1. Words then emerge in order on consecutive cycles.
- Full/overflow, DEPTH=4: ready=0, write 5 words 1..5 -> after 4 writes count=4, in_ready=0, almost_full=1. The 5th offer sets overflow=1. Draining yields 1,2,3,4 only.
- Streaming and wrap: ready=1, in_valid=1 for 20 cycles with an incrementing pattern -> count stays 1, output sequence equals input sequence delayed by 1 cycle, pointers wrap 5 times with no loss.
- Mid-operation reset: count=3 when reset is pulsed for 1 cycle -> valid=0, count=0 the next cycle, no stale word ever appears. With HS_TX_QUEUE_STATS_EN defined, xfer_cnt=0 and stall_cnt=0.
